layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Runs NUM_LAYERS passes through a shared array of NUM_UNITS compute units.
//  Per layer: one start pulse to the array, then waits until every enabled unit reports done.
//  Done pulses may arrive in any cycle and order; they are captured as sticky flags.
//  Pulses DONE after the last layer. Sits between the host/top control and the unit array.
// PARAMETERS
//  NUM_UNITS       4     number of compute units (done inputs)
//  NUM_LAYERS      3     layers per run; >=1
//  LAYER_W         2     width of LAYER_IDX; must satisfy 2**LAYER_W >= NUM_LAYERS
//  TIMEOUT_CYCLES  1024  WAIT-state watchdog limit; used only when LAYER_SEQ_TIMEOUT_EN is defined
// PORTS
//  CLK          in   1          clock, all logic on posedge
//  RST          in   1          synchronous, active-high reset
//  START        in   1          begin a run; sampled only in IDLE
//  ABORT        in   1          cancel the run; highest priority after RST
//  UNIT_MASK    in   NUM_UNITS  1 = unit takes part; sampled on accepted START, held for the run
//  UNIT_DONE    in   NUM_UNITS  per-unit done pulse/level from the array
//  LAYER_START  out  1          1-cycle pulse: array starts the layer given by LAYER_IDX
//  LAYER_IDX    out  LAYER_W    current layer, 0..NUM_LAYERS-1
//  PENDING      out  NUM_UNITS  enabled units not yet done in the current layer
//  BUSY         out  1          high in every state except IDLE
//  DONE         out  1          1-cycle pulse: run completed
//  ERROR        out  1          sticky watchdog flag (macro only; else tied 0)
// BEHAVIOUR
//  - Reset: state IDLE; LAYER_IDX=0, flags=0, mask=0, PENDING=0; LAYER_START/BUSY/DONE/ERROR=0.
//  - Outputs are Moore decodes of registered state:
//      LAYER_START=(ISSUE), DONE=(FINISH), BUSY=(state!=IDLE).
//  - FSM states: IDLE, ISSUE, WAIT, ADVANCE, FINISH.
//    * IDLE: on START, latch UNIT_MASK, set LAYER_IDX=0, go to ISSUE.
//    * ISSUE: 1 cycle. Clear done flags, then go to WAIT.
//    * WAIT: flags |= UNIT_DONE & mask.
//      all_done = &(flags | UNIT_DONE | ~mask), evaluated combinationally.
//      Leave for ADVANCE in the same cycle all_done is true.
//    * ADVANCE: if LAYER_IDX==NUM_LAYERS-1, go to FINISH; else LAYER_IDX++ and go to ISSUE.
//    * FINISH: 1 cycle, then go to IDLE. LAYER_IDX holds its last value until the next START.
//  - UNIT_DONE is ignored outside WAIT, including in the LAYER_START cycle.
//    A level held high counts once per layer.
//  - Minimum timing: 3 cycles per layer. START at cycle t gives LAYER_START at t+1, t+4, ...
//    DONE comes at t+3*NUM_LAYERS+1.
//  - PENDING = mask & ~flags in WAIT; 0 in all other states.
//  - All-zero mask: every WAIT lasts 1 cycle; the run still issues every LAYER_START.
//  - START while BUSY is ignored. START with ABORT in IDLE: ABORT wins, stay in IDLE.
//  - ABORT in any non-IDLE state: IDLE next cycle, flags cleared, no DONE pulse.
//    ABORT in FINISH still lets that cycle's DONE through.
//  - RST mid-run: behaves as a full reset; no DONE.
// CONFIGURATION
//  LAYER_SEQ_TIMEOUT_EN defined:
//   - A wait counter clears in ISSUE and increments every WAIT cycle.
//   - If all_done is false when the counter reaches TIMEOUT_CYCLES-1: go to IDLE and set ERROR.
//   - all_done in that same cycle wins: no error.
//   - ERROR stays high until the next accepted START or RST. ABORT does not clear it.
//  LAYER_SEQ_TIMEOUT_EN undefined:
//   - No counter; WAIT lasts indefinitely; ERROR tied 0.
// TESTING
//  1. Mask=4'hF; START at c0; all UNIT_DONE pulse in each WAIT.
//     -> LAYER_START at c1,c4,c7; LAYER_IDX 0,1,2; DONE at c10; BUSY c1..c10.
//  2. Staggered done: units 0..3 pulse at WAIT cycles 1,3,2,5 of layer 0.
//     -> PENDING 4'hF->E->A->8->8->0; ADVANCE in the cycle unit 3 pulses.
//  3. Mask=4'b0101; only units 0 and 2 pulse.
//     -> run completes normally; UNIT_DONE[1]/[3] pulses have no effect.
//     Mask=0 -> DONE at c10 with no done pulses.
//  4. ABORT in WAIT of layer 1 -> IDLE next cycle, BUSY=0, no DONE.
//     New START then restarts at LAYER_IDX=0.
//  5. START held high through a whole run and UNIT_DONE held high in ISSUE.
//     -> one run per accepted START; a held level is not counted early.
//     RST mid-run clears all outputs.
//  6. (LAYER_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16) unit 2 never done.
//     -> IDLE after 16 WAIT cycles, ERROR=1 until next START.
//     Done on the 16th cycle -> no ERROR.

Source files
------------

// File: rtl/layer_sequencer.sv
// Layer sequencer: issues one start per layer, waits for all enabled units.
// Optional WAIT watchdog enabled by defining LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer #(
  parameter int NUM_UNITS      = 4,
  parameter int NUM_LAYERS     = 3,
  parameter int LAYER_W        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [NUM_UNITS-1:0] UNIT_MASK,
  input  logic [NUM_UNITS-1:0] UNIT_DONE,
  output logic                 LAYER_START,
  output logic [LAYER_W-1:0]   LAYER_IDX,
  output logic [NUM_UNITS-1:0] PENDING,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERROR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_FINISH
  } state_t;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_t               state_q, state_d;
  logic [LAYER_W-1:0]   layer_q, layer_d;
  logic [NUM_UNITS-1:0] flags_q, flags_d;
  logic [NUM_UNITS-1:0] mask_q, mask_d;
  logic                 all_done;
  logic                 timeout;
  logic                 accept;

  // Same-cycle done pulses count, so a WAIT can last a single cycle.
  assign all_done = &(flags_q | UNIT_DONE | ~mask_q);
  assign accept   = (state_q == S_IDLE) && START && !ABORT;

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept) err_d = 1'b0;
    if (state_q == S_ISSUE) cnt_d = '0;
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 1'b1;
      if (!all_done && timeout && !ABORT) err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ERROR = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign ERROR   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    flags_d = flags_q;
    mask_d  = mask_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mask_d  = UNIT_MASK;
          layer_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        flags_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        flags_d = flags_q | (UNIT_DONE & mask_q);
        if (all_done) begin
          state_d = S_ADVANCE;
        end else if (timeout) begin
          state_d = S_IDLE;
          flags_d = '0;
        end
      end
      S_ADVANCE: begin
        if (layer_q == LAST_LAYER) begin
          state_d = S_FINISH;
        end else begin
          layer_d = layer_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (ABORT && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      flags_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      flags_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      flags_q <= flags_d;
      mask_q  <= mask_d;
    end
  end

  assign LAYER_START = (state_q == S_ISSUE);
  assign DONE        = (state_q == S_FINISH);
  assign BUSY        = (state_q != S_IDLE);
  assign LAYER_IDX   = layer_q;
  assign PENDING     = (state_q == S_WAIT) ? (mask_q & ~flags_q) : '0;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer.
// Build with LAYER_SEQ_TIMEOUT_EN defined to exercise the watchdog.
module tb_layer_sequencer;
  localparam int NU = 4;
  localparam int NL = 3;
  localparam int LW = 2;

  logic          CLK = 1'b0;
  logic          RST, START, ABORT;
  logic [NU-1:0] UNIT_MASK, UNIT_DONE;
  logic          LAYER_START;
  logic [LW-1:0] LAYER_IDX;
  logic [NU-1:0] PENDING;
  logic          BUSY, DONE, ERROR;

  int cmp_n = 0;
  int bad_n = 0;
  int            exp_cyc_q[$];
  logic [LW-1:0] exp_idx_q[$];

  logic [3:0] pulse_tab[5] = '{4'b0001, 4'b0100, 4'b0010, 4'b0000, 4'b1000};
  logic [3:0] pend_tab[5]  = '{4'hF, 4'hE, 4'hA, 4'h8, 4'h8};

  always #5 CLK = ~CLK;

  layer_sequencer #(
    .NUM_UNITS(NU), .NUM_LAYERS(NL), .LAYER_W(LW), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .UNIT_MASK(UNIT_MASK), .UNIT_DONE(UNIT_DONE),
    .LAYER_START(LAYER_START), .LAYER_IDX(LAYER_IDX), .PENDING(PENDING),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push_starts(input int c0, input int c1, input int c2);
    exp_cyc_q.push_back(c0); exp_idx_q.push_back(2'd0);
    exp_cyc_q.push_back(c1); exp_idx_q.push_back(2'd1);
    exp_cyc_q.push_back(c2); exp_idx_q.push_back(2'd2);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick; tick;
    cmp_n++; if (LAYER_START !== 1'b0) begin bad_n++; $display("FAIL rst_ls got %b want 0", LAYER_START); end
    cmp_n++; if (LAYER_IDX !== 2'd0) begin bad_n++; $display("FAIL rst_idx got %0d want 0", LAYER_IDX); end
    cmp_n++; if (PENDING !== 4'h0) begin bad_n++; $display("FAIL rst_pend got %h want 0", PENDING); end
    cmp_n++; if (BUSY !== 1'b0) begin bad_n++; $display("FAIL rst_busy got %b want 0", BUSY); end
    cmp_n++; if (DONE !== 1'b0) begin bad_n++; $display("FAIL rst_done got %b want 0", DONE); end
    cmp_n++; if (ERROR !== 1'b0) begin bad_n++; $display("FAIL rst_err got %b want 0", ERROR); end
    RST = 1'b0;
    tick;
    cmp_n++; if (BUSY !== 1'b0) begin bad_n++; $display("FAIL rst_idle got %b want 0", BUSY); end
  endtask

  task automatic run_simple(input logic [3:0] mask, input logic [3:0] pulse,
                            input bit hold, input string tag);
    int ec;
    logic [LW-1:0] ei;
    push_starts(1, 4, 7);
    UNIT_MASK = mask; UNIT_DONE = '0; START = 1'b1;
    tick;
    for (int c = 1; c <= 13; c++) begin
      START = hold && (c < 10);
      UNIT_DONE = (c % 3 == 2 && c <= 8) ? pulse : 4'h0;
      if (LAYER_START === 1'b1) begin
        cmp_n++;
        if (exp_cyc_q.size() == 0) begin
          bad_n++; $display("FAIL %s extra layer_start at c%0d", tag, c);
        end else begin
          ec = exp_cyc_q.pop_front(); ei = exp_idx_q.pop_front();
          if (c !== ec || LAYER_IDX !== ei) begin
            bad_n++;
            $display("FAIL %s layer_start c%0d idx %0d want c%0d idx %0d", tag, c, LAYER_IDX, ec, ei);
          end
        end
      end
      cmp_n++; if (DONE !== (c == 10)) begin bad_n++; $display("FAIL %s done c%0d got %b", tag, c, DONE); end
      cmp_n++; if (BUSY !== (c <= 10)) begin bad_n++; $display("FAIL %s busy c%0d got %b", tag, c, BUSY); end
      if (c % 3 == 2 && c <= 8) begin
        cmp_n++;
        if (PENDING !== mask) begin bad_n++; $display("FAIL %s pend c%0d got %h want %h", tag, c, PENDING, mask); end
      end
      tick;
    end
    START = 1'b0; UNIT_DONE = '0;
    cmp_n++;
    if (exp_cyc_q.size() != 0) begin
      bad_n++; $display("FAIL %s missing layer_starts got %0d left want 0", tag, exp_cyc_q.size());
      exp_cyc_q.delete(); exp_idx_q.delete();
    end
    cmp_n++; if (ERROR !== 1'b0) begin bad_n++; $display("FAIL %s err got %b want 0", tag, ERROR); end
  endtask

  task automatic test_full_run;
    run_simple(4'hF, 4'hF, 1'b0, "full");
  endtask

  task automatic test_staggered;
    int ec;
    logic [LW-1:0] ei;
    push_starts(1, 8, 11);
    UNIT_MASK = 4'hF; START = 1'b1;
    tick;
    START = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c >= 2 && c <= 6) UNIT_DONE = pulse_tab[c-2];
      else UNIT_DONE = (c == 9 || c == 12) ? 4'hF : 4'h0;
      if (LAYER_START === 1'b1) begin
        cmp_n++;
        if (exp_cyc_q.size() == 0) begin
          bad_n++; $display("FAIL stag extra layer_start at c%0d", c);
        end else begin
          ec = exp_cyc_q.pop_front(); ei = exp_idx_q.pop_front();
          if (c !== ec || LAYER_IDX !== ei) begin
            bad_n++;
            $display("FAIL stag layer_start c%0d idx %0d want c%0d idx %0d", c, LAYER_IDX, ec, ei);
          end
        end
      end
      if (c >= 2 && c <= 7) begin
        cmp_n++;
        if (PENDING !== ((c == 7) ? 4'h0 : pend_tab[c-2])) begin
          bad_n++; $display("FAIL stag pend c%0d got %h", c, PENDING);
        end
      end
      cmp_n++; if (DONE !== (c == 14)) begin bad_n++; $display("FAIL stag done c%0d got %b", c, DONE); end
      cmp_n++; if (BUSY !== (c <= 14)) begin bad_n++; $display("FAIL stag busy c%0d got %b", c, BUSY); end
      tick;
    end
    UNIT_DONE = '0;
    cmp_n++;
    if (exp_cyc_q.size() != 0) begin
      bad_n++; $display("FAIL stag missing layer_starts got %0d left want 0", exp_cyc_q.size());
      exp_cyc_q.delete(); exp_idx_q.delete();
    end
  endtask

  task automatic test_mask;
    UNIT_MASK = 4'b0101; START = 1'b1;
    tick;
    START = 1'b0;
    tick;
    cmp_n++; if (PENDING !== 4'h5) begin bad_n++; $display("FAIL mask_pend0 got %h want 5", PENDING); end
    UNIT_DONE = 4'b1010;
    tick;
    cmp_n++;
    if (BUSY !== 1'b1 || LAYER_START !== 1'b0 || PENDING !== 4'h5) begin
      bad_n++; $display("FAIL mask_ignore busy %b ls %b pend %h want 1 0 5", BUSY, LAYER_START, PENDING);
    end
    UNIT_DONE = 4'b0101;
    tick;
    UNIT_DONE = 4'h0;
    cmp_n++; if (PENDING !== 4'h0 || BUSY !== 1'b1) begin bad_n++; $display("FAIL mask_adv pend %h busy %b", PENDING, BUSY); end
    tick;
    cmp_n++;
    if (LAYER_START !== 1'b1 || LAYER_IDX !== 2'd1) begin
      bad_n++; $display("FAIL mask_l1 ls %b idx %0d want 1 1", LAYER_START, LAYER_IDX);
    end
    ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
    cmp_n++; if (BUSY !== 1'b0) begin bad_n++; $display("FAIL mask_abort busy %b want 0", BUSY); end
    run_simple(4'b0101, 4'hF, 1'b0, "mask5");
    run_simple(4'h0, 4'h0, 1'b0, "mask0");
  endtask

  task automatic test_abort;
    UNIT_MASK = 4'hF; START = 1'b1;
    tick;
    START = 1'b0;
    tick;
    UNIT_DONE = 4'hF;
    tick;
    UNIT_DONE = 4'h0;
    tick;
    cmp_n++;
    if (LAYER_START !== 1'b1 || LAYER_IDX !== 2'd1) begin
      bad_n++; $display("FAIL abort_l1 ls %b idx %0d want 1 1", LAYER_START, LAYER_IDX);
    end
    tick;
    cmp_n++; if (PENDING !== 4'hF) begin bad_n++; $display("FAIL abort_wait pend %h want f", PENDING); end
    ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
    cmp_n++;
    if (BUSY !== 1'b0 || PENDING !== 4'h0) begin
      bad_n++; $display("FAIL abort_idle busy %b pend %h want 0 0", BUSY, PENDING);
    end
    for (int i = 0; i < 8; i++) begin
      cmp_n++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
        bad_n++; $display("FAIL abort_quiet i%0d done %b busy %b", i, DONE, BUSY);
      end
      tick;
    end
    START = 1'b1; ABORT = 1'b1;
    tick;
    START = 1'b0; ABORT = 1'b0;
    cmp_n++;
    if (BUSY !== 1'b0 || LAYER_START !== 1'b0) begin
      bad_n++; $display("FAIL start_abort busy %b ls %b want 0 0", BUSY, LAYER_START);
    end
    run_simple(4'hF, 4'hF, 1'b0, "restart");
  endtask

  task automatic test_back_to_back;
    run_simple(4'hF, 4'hF, 1'b1, "held_start");
  endtask

  task automatic test_held_level;
    int ec;
    logic [LW-1:0] ei;
    push_starts(1, 5, 8);
    UNIT_MASK = 4'hF; START = 1'b1;
    tick;
    START = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      UNIT_DONE = (c == 1 || c >= 3) ? 4'hF : 4'h0;
      if (LAYER_START === 1'b1) begin
        cmp_n++;
        if (exp_cyc_q.size() == 0) begin
          bad_n++; $display("FAIL held extra layer_start at c%0d", c);
        end else begin
          ec = exp_cyc_q.pop_front(); ei = exp_idx_q.pop_front();
          if (c !== ec || LAYER_IDX !== ei) begin
            bad_n++;
            $display("FAIL held layer_start c%0d idx %0d want c%0d idx %0d", c, LAYER_IDX, ec, ei);
          end
        end
      end
      if (c >= 2 && c <= 4) begin
        cmp_n++;
        if (PENDING !== ((c == 4) ? 4'h0 : 4'hF)) begin
          bad_n++; $display("FAIL held pend c%0d got %h", c, PENDING);
        end
      end
      cmp_n++; if (DONE !== (c == 11)) begin bad_n++; $display("FAIL held done c%0d got %b", c, DONE); end
      cmp_n++; if (BUSY !== (c <= 11)) begin bad_n++; $display("FAIL held busy c%0d got %b", c, BUSY); end
      tick;
    end
    UNIT_DONE = '0;
    cmp_n++;
    if (exp_cyc_q.size() != 0) begin
      bad_n++; $display("FAIL held missing layer_starts got %0d left want 0", exp_cyc_q.size());
      exp_cyc_q.delete(); exp_idx_q.delete();
    end
  endtask

  task automatic test_reset_midrun;
    UNIT_MASK = 4'hF; START = 1'b1;
    tick;
    START = 1'b0;
    tick;
    UNIT_DONE = 4'hF;
    tick;
    UNIT_DONE = 4'h0;
    tick; tick;
    cmp_n++; if (PENDING !== 4'hF) begin bad_n++; $display("FAIL mid_pend got %h want f", PENDING); end
    RST = 1'b1;
    tick;
    cmp_n++;
    if ({LAYER_START, LAYER_IDX, PENDING, BUSY, DONE, ERROR} !== 10'b0) begin
      bad_n++;
      $display("FAIL mid_rst ls %b idx %0d pend %h busy %b done %b err %b want all 0",
               LAYER_START, LAYER_IDX, PENDING, BUSY, DONE, ERROR);
    end
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cmp_n++;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
        bad_n++; $display("FAIL mid_quiet i%0d done %b busy %b", i, DONE, BUSY);
      end
      tick;
    end
  endtask

  task automatic test_timeout;
`ifdef LAYER_SEQ_TIMEOUT_EN
    UNIT_MASK = 4'hF; START = 1'b1;
    tick;
    START = 1'b0;
    tick;
    UNIT_DONE = 4'b1011;
    for (int c = 2; c <= 17; c++) begin
      cmp_n++;
      if (BUSY !== 1'b1 || ERROR !== 1'b0) begin
        bad_n++; $display("FAIL to_wait c%0d busy %b err %b want 1 0", c, BUSY, ERROR);
      end
      tick;
    end
    cmp_n++; if (BUSY !== 1'b0) begin bad_n++; $display("FAIL to_idle busy %b want 0", BUSY); end
    cmp_n++; if (ERROR !== 1'b1) begin bad_n++; $display("FAIL to_err got %b want 1", ERROR); end
    UNIT_DONE = 4'h0; ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
    tick;
    cmp_n++; if (ERROR !== 1'b1) begin bad_n++; $display("FAIL to_sticky got %b want 1", ERROR); end
    START = 1'b1;
    tick;
    START = 1'b0;
    cmp_n++;
    if (ERROR !== 1'b0 || LAYER_START !== 1'b1) begin
      bad_n++; $display("FAIL to_clear err %b ls %b want 0 1", ERROR, LAYER_START);
    end
    tick;
    for (int c = 2; c <= 17; c++) begin
      UNIT_DONE = (c == 17) ? 4'hF : 4'b1011;
      tick;
    end
    UNIT_DONE = 4'h0;
    cmp_n++;
    if (BUSY !== 1'b1 || PENDING !== 4'h0 || ERROR !== 1'b0 || LAYER_START !== 1'b0) begin
      bad_n++;
      $display("FAIL to_last busy %b pend %h err %b ls %b want 1 0 0 0", BUSY, PENDING, ERROR, LAYER_START);
    end
    ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
    cmp_n++; if (BUSY !== 1'b0 || ERROR !== 1'b0) begin bad_n++; $display("FAIL to_end busy %b err %b", BUSY, ERROR); end
`else
    UNIT_MASK = 4'hF; START = 1'b1;
    tick;
    START = 1'b0;
    UNIT_DONE = 4'b1011;
    for (int c = 1; c <= 40; c++) begin
      tick;
      cmp_n++;
      if (BUSY !== 1'b1 || ERROR !== 1'b0) begin
        bad_n++; $display("FAIL nowd c%0d busy %b err %b want 1 0", c, BUSY, ERROR);
      end
    end
    UNIT_DONE = 4'h0; ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
    cmp_n++; if (BUSY !== 1'b0) begin bad_n++; $display("FAIL nowd_abort busy %b want 0", BUSY); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; START = 1'b0; ABORT = 1'b0;
    UNIT_MASK = '0; UNIT_DONE = '0;
    test_reset;
    test_full_run;
    test_staggered;
    test_mask;
    test_abort;
    test_back_to_back;
    test_held_level;
    test_reset_midrun;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end
endmodule
